mc_alu_controller: RTL and testbench

//  Multi-cycle control FSM for the 16-bit MIPS-style datapath. It is the initiator side of the
//  ALU interface: it decodes the instruction register opcode, drives sig_op/operand selects,
//  and consumes the ALU zero flag for BEQ. It also sequences instruction memory, register-file
//  and PC write strobes, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/alu_op_decode.sv | 24 ++
 rtl/mc_alu_controller.sv | 193 +++++++++++++++++++
 tb/tb_mc_alu_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared codes and state encoding for the multi-cycle ALU controller
// Contents: instruction opcodes, ALU sig_op codes, operand-B and PC-source select codes,
// and the controller state enum.
package mc_ctrl_pkg;

    // Instruction opcodes (IR[15:12]); 10-15 are undefined.
    localparam logic [3:0] OPC_ADD  = 4'd0;
    localparam logic [3:0] OPC_SUB  = 4'd1;
    localparam logic [3:0] OPC_AND  = 4'd2;
    localparam logic [3:0] OPC_OR   = 4'd3;
    localparam logic [3:0] OPC_NOT  = 4'd4;
    localparam logic [3:0] OPC_MOVI = 4'd5;
    localparam logic [3:0] OPC_LW   = 4'd6;
    localparam logic [3:0] OPC_SW   = 4'd7;
    localparam logic [3:0] OPC_BEQ  = 4'd8;
    localparam logic [3:0] OPC_JMP  = 4'd9;

    // ALU operation codes driven on sig_op; 6 and 7 are never produced.
    localparam logic [2:0] OP_PASSB = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_NOTB  = 3'd5;

    // ALU operand A select.
    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_REGA = 1'b1;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REGB   = 2'd0;
    localparam logic [1:0] SRCB_CONST1 = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;

    // PC load source select.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps register-type opcodes to the ALU operation code
// Ports:
//   opcode  in  4  instruction opcode (only 0-4 are meaningful here)
//   sig_op  out 3  ALU operation for the EXEC_R state
module alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] sig_op
);

    always_comb begin
        sig_op = OP_PASSB;
        case (opcode)
            OPC_ADD: sig_op = OP_ADD;
            OPC_SUB: sig_op = OP_SUB;
            OPC_AND: sig_op = OP_AND;
            OPC_OR:  sig_op = OP_OR;
            OPC_NOT: sig_op = OP_NOTB;
            default: sig_op = OP_PASSB;
        endcase
    end

endmodule

// File: rtl/mc_alu_controller.sv
// rtl/mc_alu_controller.sv - multi-cycle control FSM for the 16-bit MIPS-style datapath
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   opcode               IR[15:12], valid from DECODE onward
//   zero                 ALU zero flag, consumed by BEQ
//   mem_ready            memory access completes in a cycle where it is 1
//   sig_op               ALU operation code
//   alu_src_a/alu_src_b  ALU operand selects
//   mem_read/mem_write   memory requests; i_or_d picks PC (0) or ALUOut (1) address
//   ir_write, pc_write   instruction register and PC load strobes; pc_src picks PC source
//   reg_write            register-file write strobe; mem_to_reg picks ALUOut (0) or MDR (1)
//   instr_done           one-cycle pulse when an instruction retires
//   illegal_op           one-cycle pulse in DECODE for an undefined opcode
//   instr_count          retired-instruction counter, wraps modulo 2^CNT_W
module mc_alu_controller
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int PC_INC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       sig_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    // The PC step is produced by the ALU adding the constant-1 operand; PC_INC only
    // records that fact, so the FETCH operand select is the single place it appears.
    localparam logic [1:0] SRCB_PC_STEP = (PC_INC == 1) ? SRCB_CONST1 : SRCB_CONST1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [2:0]       r_sig_op;
    logic             retire;

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .sig_op (r_sig_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    assign instr_count = instr_count_q;

    always_comb begin
        state_d    = state_q;
        sig_op     = OP_PASSB;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_PC_STEP;
                sig_op    = OP_ADD;
                // IR and PC+1 are captured only in the cycle the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = SRCB_IMM;
                sig_op    = OP_ADD;
                case (opcode)
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_NOT: state_d = ST_EXEC_R;
                    OPC_MOVI:                                   state_d = ST_EXEC_I;
                    OPC_LW, OPC_SW:                             state_d = ST_MEM_ADDR;
                    OPC_BEQ:                                    state_d = ST_BRANCH;
                    OPC_JMP:                                    state_d = ST_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                sig_op    = r_sig_op;
                state_d   = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_b = SRCB_IMM;
                sig_op    = OP_PASSB;
                state_d   = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                sig_op    = OP_ADD;
                state_d   = (opcode == OPC_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                sig_op    = OP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // The state register resets to FETCH, whose read request is unconditional, so
        // the strobes are also masked directly while reset is held.
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
        instr_done = retire & rst_n;
    end

endmodule

// File: tb/tb_mc_alu_controller.sv
// tb/tb_mc_alu_controller.sv - scoreboard bench for the multi-cycle ALU controller
module tb_mc_alu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  sig_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write, mem_to_reg, instr_done, illegal_op;
    logic [15:0] instr_count;

    mc_alu_controller #(.CNT_W(16), .PC_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .sig_op(sig_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          illegal;
        int          cycles;
        logic [15:0] cnt;
        logic [3:0]  op;
        bit          z;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Cycle counts with no memory stalls: R/MOVI/SW 4, LW 5, BEQ/JMP 3, illegal 2.
    function automatic int base_cycles(input logic [3:0] op);
        if (op <= 4'd5 || op == 4'd7) return 4;
        if (op == 4'd6) return 5;
        if (op == 4'd8 || op == 4'd9) return 3;
        return 2;
    endfunction

    task automatic run_instr(input logic [3:0] op, input int f, input int m, input bit z);
        bit   mr[$];
        exp_t e;
        for (int i = 0; i < f; i++) mr.push_back(1'b0);
        mr.push_back(1'b1);                       // fetch completes
        mr.push_back(1'($urandom));               // decode
        if (op <= 4'd5 || op >= 4'd8 && op <= 4'd9) begin
            mr.push_back(1'($urandom));
            if (op <= 4'd5) mr.push_back(1'($urandom));
        end else if (op == 4'd6 || op == 4'd7) begin
            mr.push_back(1'($urandom));           // address calculation
            for (int i = 0; i < m; i++) mr.push_back(1'b0);
            mr.push_back(1'b1);
            if (op == 4'd6) mr.push_back(1'($urandom));
        end
        e.illegal = (op > 4'd9);
        e.cycles  = base_cycles(op) + f + ((op == 4'd6 || op == 4'd7) ? m : 0);
        e.cnt     = model_count;
        e.op      = op;
        e.z       = z;
        exp_q.push_back(e);
        if (!e.illegal) model_count = model_count + 16'd1;
        foreach (mr[i]) begin
            opcode    = op;
            zero      = z;
            mem_ready = mr[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_strobes", {mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal_op}, 7'b0);
        chk("reset_count", instr_count, 16'd0);
        model_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_release_read", {mem_read, i_or_d}, 2'b10);
        chk("post_release_writes", {mem_write, ir_write, pc_write, reg_write, instr_done, illegal_op}, 6'b0);
    endtask

    // Monitor: compares each retire / illegal pulse against the scoreboard head.
    int         cyc = 0;
    logic [2:0] prev_sig_op;
    logic       prev_src_a;
    logic [1:0] prev_src_b;
    logic       prev_mem_read, prev_i_or_d;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0;
            end else begin
                cyc++;
                chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
                chk("sig_op_range", {31'b0, sig_op > 3'd5}, 32'd0);
                if (instr_done || illegal_op) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {instr_done, illegal_op}, 2'b00);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("latency", cyc, e.cycles);
                        chk("count_at_event", instr_count, e.cnt);
                        if (e.illegal) begin
                            chk("illegal_pulse", {illegal_op, instr_done}, 2'b10);
                            chk("illegal_decode_alu", {sig_op, alu_src_a, alu_src_b}, {3'd1, 1'b0, 2'd2});
                            chk("illegal_no_write", {reg_write, pc_write, mem_write}, 3'b0);
                        end else begin
                            chk("done_pulse", {illegal_op, instr_done}, 2'b01);
                            if (e.op <= 4'd4) begin
                                chk("r_wb", {reg_write, mem_to_reg, pc_write, mem_write}, 4'b1000);
                                chk("r_exec_op", prev_sig_op, e.op + 4'd1);
                                chk("r_exec_src", {prev_src_a, prev_src_b}, 3'b100);
                            end else if (e.op == 4'd5) begin
                                chk("movi_wb", {reg_write, mem_to_reg, pc_write}, 3'b100);
                                chk("movi_exec", {prev_sig_op, prev_src_b}, {3'd0, 2'd2});
                            end else if (e.op == 4'd6) begin
                                chk("lw_wb", {reg_write, mem_to_reg, mem_read}, 3'b110);
                                chk("lw_mem_rd", {prev_mem_read, prev_i_or_d}, 2'b11);
                            end else if (e.op == 4'd7) begin
                                chk("sw_mem_wr", {mem_write, i_or_d, mem_read, reg_write}, 4'b1100);
                            end else if (e.op == 4'd8) begin
                                chk("beq_alu", {sig_op, alu_src_a, alu_src_b}, {3'd2, 1'b1, 2'd0});
                                chk("beq_pc", {pc_src, pc_write, reg_write}, {2'd1, e.z, 1'b0});
                            end else begin
                                chk("jmp_pc", {pc_src, pc_write, reg_write}, {2'd2, 1'b1, 1'b0});
                            end
                        end
                    end
                    cyc = 0;
                end else if (cyc > 60) begin
                    chk("event_timeout", cyc, 60);
                    cyc = 0;
                end
                prev_sig_op   = sig_op;
                prev_src_a    = alu_src_a;
                prev_src_b    = alu_src_b;
                prev_mem_read = mem_read;
                prev_i_or_d   = i_or_d;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        // Directed cases.
        run_instr(4'd0, 0, 0, 1'b0);              // ADD, 4 cycles, count 0 -> 1
        run_instr(4'd6, 0, 3, 1'b0);              // LW with 3 stalls, 8 cycles
        run_instr(4'd8, 0, 0, 1'b1);              // BEQ taken
        run_instr(4'd8, 0, 0, 1'b0);              // BEQ not taken, still retires
        run_instr(4'd12, 0, 0, 1'b0);             // illegal, count unchanged
        run_instr(4'd7, 1, 2, 1'b0);              // SW with fetch and write stalls

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(0, 3)), 1'($urandom));
        end
        chk("drain_before_abort", exp_q.size(), 0);
        chk("count_before_abort", instr_count, model_count);

        // Reset in the middle of a stalled store.
        begin
            bit seq[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 5; i++) begin
                opcode    = 4'd7;
                mem_ready = seq[i];
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b0;
            #1;
            chk("sw_stalled_write", {mem_write, i_or_d}, 2'b11);
            do_reset();
        end
        run_instr(4'd1, 0, 0, 1'b0);
        chk("count_after_abort", instr_count, 16'd1);

        // Counter wrap: preload just below the top value.
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        model_count = 16'hFFFE;
        run_instr(4'd9, 0, 0, 1'b0);
        run_instr(4'd9, 0, 0, 1'b0);
        run_instr(4'd0, 0, 0, 1'b0);              // sees 0x0000 at its retire
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", exp_q.size(), 0);
        chk("final_count", instr_count, model_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
